// File: rtl/tone_port.sv
// Square-wave tone generator driven by port writes: one note plays while at most one more waits.
// Registered outputs update one cycle after a write; writes are never stalled, a full pending slot is overwritten and flagged.
module tone_port #(
  parameter int TICK_CYCLES = 50000,
  parameter int HP_SHIFT    = 0,
  parameter int GAP_TICKS   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_we,
  input  logic [7:0] cmd_data,
  output logic       tone_out,
  output logic       busy,
  output logic [7:0] status
);

  localparam int DUR_MAX  = ((GAP_TICKS > 512) ? GAP_TICKS : 512) * TICK_CYCLES;
  localparam int CW       = $clog2(DUR_MAX + 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_TICKS * TICK_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

  state_t          state_q, state_d;
  logic            tone_q, tone_d;
  logic [7:0]      pend_q, pend_d;
  logic            pend_full_q, pend_full_d;
  logic            overrun_q, overrun_d;
  logic [7:0]      cur_cmd_q, cur_cmd_d;
  logic [16:0]     hp_cnt_q, hp_cnt_d;
  logic [CW-1:0]   dur_cnt_q, dur_cnt_d;

  logic            wr, abort, go_play, take_pend, take_direct;
  logic [7:0]      play_cmd;
  logic [16:0]     hp_half;
  logic [CW-1:0]   play_last;

  // Half-period in clk cycles at 50 MHz, equal temperament anchored on A4 = 440 Hz.
  function automatic logic [16:0] hp_rom(input logic [4:0] n);
    case (n)
      5'd1:  hp_rom = 17'd95556;
      5'd2:  hp_rom = 17'd90193;
      5'd3:  hp_rom = 17'd85131;
      5'd4:  hp_rom = 17'd80353;
      5'd5:  hp_rom = 17'd75843;
      5'd6:  hp_rom = 17'd71586;
      5'd7:  hp_rom = 17'd67569;
      5'd8:  hp_rom = 17'd63776;
      5'd9:  hp_rom = 17'd60197;
      5'd10: hp_rom = 17'd56818;
      5'd11: hp_rom = 17'd53629;
      5'd12: hp_rom = 17'd50619;
      5'd13: hp_rom = 17'd47778;
      5'd14: hp_rom = 17'd45097;
      5'd15: hp_rom = 17'd42566;
      5'd16: hp_rom = 17'd40177;
      5'd17: hp_rom = 17'd37922;
      5'd18: hp_rom = 17'd35793;
      5'd19: hp_rom = 17'd33784;
      5'd20: hp_rom = 17'd31888;
      5'd21: hp_rom = 17'd30098;
      5'd22: hp_rom = 17'd28409;
      5'd23: hp_rom = 17'd26815;
      5'd24: hp_rom = 17'd25310;
      default: hp_rom = 17'd0;
    endcase
  endfunction

  function automatic logic is_tone(input logic [4:0] n);
    is_tone = (n >= 5'd1) && (n <= 5'd24);
  endfunction

  always_comb begin
    state_d     = state_q;
    tone_d      = tone_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    overrun_d   = overrun_q;
    cur_cmd_d   = cur_cmd_q;
    hp_cnt_d    = hp_cnt_q;
    dur_cnt_d   = dur_cnt_q;
    go_play     = 1'b0;
    take_pend   = 1'b0;
    take_direct = 1'b0;
    play_cmd    = pend_q;

    wr        = cmd_we && (cmd_data[4:0] != 5'd31);
    abort     = cmd_we && (cmd_data[4:0] == 5'd31);
    hp_half   = hp_rom(cur_cmd_q[4:0]) >> HP_SHIFT;
    play_last = CW'((int'(cur_cmd_q[7:5]) + 1) * 64 * TICK_CYCLES - 1);

    case (state_q)
      IDLE: begin
        if (pend_full_q) begin
          take_pend = 1'b1;
        end else if (wr) begin
          take_direct = 1'b1;
        end
      end
      PLAY: begin
        if (dur_cnt_q == play_last) begin
          state_d   = GAP;
          tone_d    = 1'b0;
          hp_cnt_d  = '0;
          dur_cnt_d = '0;
        end else begin
          dur_cnt_d = dur_cnt_q + CW'(1);
          if (is_tone(cur_cmd_q[4:0])) begin
            if ({1'b0, hp_cnt_q} + 18'd1 >= {1'b0, hp_half}) begin
              hp_cnt_d = '0;
              tone_d   = ~tone_q;
            end else begin
              hp_cnt_d = hp_cnt_q + 17'd1;
            end
          end
        end
      end
      GAP: begin
        if (dur_cnt_q == GAP_LAST) begin
          if (pend_full_q) begin
            take_pend = 1'b1;
          end else if (wr) begin
            take_direct = 1'b1;
          end else begin
            state_d   = IDLE;
            cur_cmd_d = '0;
            dur_cnt_d = '0;
          end
        end else begin
          dur_cnt_d = dur_cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (take_pend) begin
      go_play     = 1'b1;
      play_cmd    = pend_q;
      pend_full_d = 1'b0;
    end else if (take_direct) begin
      go_play  = 1'b1;
      play_cmd = cmd_data;
    end

    // A write not consumed directly lands in the slot; only losing an unplayed command counts as overrun.
    if (wr && !take_direct) begin
      pend_d      = cmd_data;
      pend_full_d = 1'b1;
      if (pend_full_q && !take_pend) begin
        overrun_d = 1'b1;
      end
    end

    if (go_play) begin
      state_d   = PLAY;
      cur_cmd_d = play_cmd;
      tone_d    = is_tone(play_cmd[4:0]);
      hp_cnt_d  = '0;
      dur_cnt_d = '0;
    end

    if (abort) begin
      state_d     = IDLE;
      tone_d      = 1'b0;
      pend_full_d = 1'b0;
      overrun_d   = 1'b0;
      cur_cmd_d   = '0;
      hp_cnt_d    = '0;
      dur_cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      tone_q      <= 1'b0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      overrun_q   <= 1'b0;
      cur_cmd_q   <= '0;
      hp_cnt_q    <= '0;
      dur_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      tone_q      <= tone_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      overrun_q   <= overrun_d;
      cur_cmd_q   <= cur_cmd_d;
      hp_cnt_q    <= hp_cnt_d;
      dur_cnt_q   <= dur_cnt_d;
    end
  end

  assign tone_out = tone_q;
  assign busy     = (state_q != IDLE);
  assign status   = {busy, pend_full_q, overrun_q, cur_cmd_q[4:0]};

endmodule
